cylon_decoder: RTL and testbench

//  Receive-side monitor for the 12-LED cylon display pattern. It samples the 12-bit LED vector,

---
 rtl/cylon_pkg.sv | 29 ++
 rtl/cylon_onehot_enc.sv | 28 ++
 rtl/cylon_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_cylon_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cylon_pkg.sv
// Shared constants, state encoding and step helpers for the cylon LED pattern monitor.
package cylon_pkg;

  localparam int unsigned MXLED = 12;
  localparam logic [MXLED-1:0] INIT_PAT = '1;
  localparam logic [3:0] POS_LAST = 4'(MXLED - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    UP      = 2'd2,
    DOWN    = 2'd3
  } cylon_state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_ONEHOT = 2'd1;
  localparam logic [1:0] ERR_STEP   = 2'd2;
  localparam logic [1:0] ERR_STALL  = 2'd3;

  // Position 0 has no predecessor; the wrapped value 15 never matches a valid position.
  function automatic logic is_next(input logic [3:0] cur, input logic [3:0] p);
    return p == 4'(cur + 4'd1);
  endfunction

  function automatic logic is_prev(input logic [3:0] cur, input logic [3:0] p);
    return p == 4'(cur - 4'd1);
  endfunction

endpackage

// File: rtl/cylon_onehot_enc.sv
// Combinational classifier/encoder for one sampled LED vector.
module cylon_onehot_enc
  import cylon_pkg::*;
(
  input  logic [MXLED-1:0] led,
  output logic [3:0]       pos,
  output logic             is_onehot,
  output logic             is_init,
  output logic             is_zero
);

  localparam logic [MXLED-1:0] ONE = {{(MXLED-1){1'b0}}, 1'b1};

  logic [MXLED-1:0] w_dec;

  assign w_dec     = led - ONE;
  assign is_zero   = ~|led;
  assign is_init   = (led == INIT_PAT);
  assign is_onehot = !is_zero && ((led & w_dec) == '0);

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < MXLED; i++) begin
      if (led[i]) pos = 4'(i);
    end
  end

endmodule

// File: rtl/cylon_decoder.sv
// Cylon LED pattern monitor: decodes position, tracks direction, counts sweeps, latches errors.
// Optional stall detection is built when CYLON_DECODER_STALL_EN is defined.
module cylon_decoder
  import cylon_pkg::*;
#(
  parameter int unsigned MXCNT = 16,
  parameter int unsigned MXTMO = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [MXLED-1:0] led,
  input  logic             err_clr,
  output logic [3:0]       pos,
  output logic             dir,
  output logic             locked,
  output logic [MXCNT-1:0] sweeps,
  output logic             err,
  output logic [1:0]       err_code
);

  if (MXTMO < 2 || MXCNT < 1) begin : g_cfg_chk
    $error("cylon_decoder: MXTMO must be >= 2 and MXCNT >= 1");
  end

  localparam logic [MXCNT-1:0] CNT_ONE = {{(MXCNT-1){1'b0}}, 1'b1};

  logic [MXLED-1:0] r_led_q;
  logic [MXLED-1:0] r_led_qq;
  cylon_state_t     r_state;
  cylon_state_t     w_nxt_state;
  logic [3:0]       r_pos;
  logic [3:0]       w_nxt_pos;
  logic             r_dir;
  logic             w_nxt_dir;
  logic [MXCNT-1:0] r_sweeps;
  logic [MXCNT-1:0] w_nxt_sweeps;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic             w_err_new;
  logic [1:0]       w_err_kind;
  logic             w_event;
  logic             w_locked;
  logic             w_stall;
  logic [3:0]       w_p;
  logic             w_is_onehot;
  logic             w_is_init;
  logic             w_is_zero;

  // Input regs keep sampling while disabled so re-enabling does not see a stale change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_led_q  <= '0;
      r_led_qq <= '0;
    end else begin
      r_led_q  <= led;
      r_led_qq <= r_led_q;
    end
  end

  assign w_event  = enable && (r_led_q != r_led_qq);
  assign w_locked = (r_state == UP) || (r_state == DOWN);

  cylon_onehot_enc u_enc (
    .led       (r_led_q),
    .pos       (w_p),
    .is_onehot (w_is_onehot),
    .is_init   (w_is_init),
    .is_zero   (w_is_zero)
  );

`ifdef CYLON_DECODER_STALL_EN
  localparam logic [MXTMO-1:0] TMO_ONE = {{(MXTMO-1){1'b0}}, 1'b1};

  logic [MXTMO-1:0] r_tmo;

  assign w_stall = enable && w_locked && !w_event && (&r_tmo);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (!enable || !w_locked || w_event || w_stall) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_ONE;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= SEARCH;
      r_pos    <= '0;
      r_dir    <= 1'b0;
      r_sweeps <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_pos    <= w_nxt_pos;
      r_dir    <= w_nxt_dir;
      r_sweeps <= w_nxt_sweeps;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_pos    = r_pos;
    w_nxt_dir    = r_dir;
    w_nxt_sweeps = r_sweeps;
    w_err_new    = 1'b0;
    w_err_kind   = ERR_NONE;

    if (w_event) begin
      if (w_is_init) begin
        w_nxt_state = SEARCH;
      end else if (w_is_zero) begin
        w_nxt_state = r_state;
      end else if (!w_is_onehot) begin
        w_err_new   = 1'b1;
        w_err_kind  = ERR_ONEHOT;
        w_nxt_state = SEARCH;
      end else begin
        w_nxt_pos = w_p;
        unique case (r_state)
          SEARCH: begin
            if (w_p == 4'd0) begin
              w_nxt_state = UP;
              w_nxt_dir   = 1'b0;
            end else if (w_p == POS_LAST) begin
              w_nxt_state = DOWN;
              w_nxt_dir   = 1'b1;
            end else begin
              w_nxt_state = ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (is_next(r_pos, w_p)) begin
              w_nxt_state = UP;
              w_nxt_dir   = 1'b0;
            end else if (is_prev(r_pos, w_p)) begin
              w_nxt_state = DOWN;
              w_nxt_dir   = 1'b1;
            end else begin
              w_err_new = 1'b1;
            end
          end
          UP: begin
            if (r_pos == POS_LAST) begin
              if (is_prev(r_pos, w_p)) begin
                w_nxt_state = DOWN;
                w_nxt_dir   = 1'b1;
              end else begin
                w_err_new = 1'b1;
              end
            end else if (!is_next(r_pos, w_p)) begin
              w_err_new = 1'b1;
            end
          end
          DOWN: begin
            if (r_pos == 4'd0) begin
              if (is_next(r_pos, w_p)) begin
                w_nxt_state = UP;
                w_nxt_dir   = 1'b0;
              end else begin
                w_err_new = 1'b1;
              end
            end else if (is_prev(r_pos, w_p)) begin
              if (w_p == 4'd0) w_nxt_sweeps = r_sweeps + CNT_ONE;
            end else begin
              w_err_new = 1'b1;
            end
          end
          default: w_nxt_state = SEARCH;
        endcase
        if (w_err_new) begin
          w_err_kind  = ERR_STEP;
          w_nxt_state = SEARCH;
        end
      end
    end else if (w_stall) begin
      w_err_new   = 1'b1;
      w_err_kind  = ERR_STALL;
      w_nxt_state = SEARCH;
    end
  end

  // A new error in the same cycle as err_clr wins and records its own code.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_err_new) begin
      r_err <= 1'b1;
      if (err_clr || (r_err_code == ERR_NONE)) r_err_code <= w_err_kind;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end
  end

  assign pos      = r_pos;
  assign dir      = r_dir;
  assign locked   = w_locked;
  assign sweeps   = r_sweeps;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_cylon_decoder.sv
// Directed self-checking bench for cylon_decoder; stall case depends on CYLON_DECODER_STALL_EN.
module tb_cylon_decoder;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [11:0] led;
  logic        err_clr;
  logic [3:0]  pos;
  logic        dir;
  logic        locked;
  logic [15:0] sweeps;
  logic        err;
  logic [1:0]  err_code;

  int unsigned checks;
  int unsigned errors;

  cylon_decoder #(
    .MXCNT (16),
    .MXTMO (4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .led      (led),
    .err_clr  (err_clr),
    .pos      (pos),
    .dir      (dir),
    .locked   (locked),
    .sweeps   (sweeps),
    .err      (err),
    .err_code (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [11:0] pat);
    @(negedge clock);
    led = pat;
    repeat (3) @(negedge clock);
  endtask

  task automatic step(input int unsigned p);
    logic [11:0] v;
    v = '0;
    v[p] = 1'b1;
    drive(v);
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    enable  = 1'b1;
    led     = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pos", pos, 0);
    check("rst_dir", dir, 0);
    check("rst_locked", locked, 0);
    check("rst_sweeps", sweeps, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    reset_n = 1'b1;

    // Full sweep: INIT, then three round trips 0..11..0
    drive(12'hFFF);
    check("init_locked", locked, 0);
    step(0);
    check("first_locked", locked, 1);
    check("first_dir", dir, 0);
    for (int t = 0; t < 3; t++) begin
      for (int p = 1; p <= 11; p++) step(p);
      check("dir_at11", dir, 0);
      for (int p = 10; p >= 0; p--) begin
        step(p);
        if (p == 10) check("dir_after11", dir, 1);
      end
      check("sweeps_trip", sweeps, t + 1);
    end
    check("sweep_err", err, 0);
    check("sweep_locked", locked, 1);

    // Malformed pattern while ascending at 5, then relock through ACQUIRE
    for (int p = 1; p <= 5; p++) step(p);
    check("asc5_pos", pos, 5);
    drive(12'b0000_1010_0000);
    check("bad_err", err, 1);
    check("bad_code", err_code, 1);
    check("bad_locked", locked, 0);
    step(7);
    check("acq_locked", locked, 0);
    check("acq_pos", pos, 7);
    step(8);
    check("relock", locked, 1);
    check("relock_dir", dir, 0);

    // Skipped step; later malformed pattern must not overwrite the code
    pulse_clr();
    check("clr_err", err, 0);
    drive(12'hFFF);
    for (int p = 0; p <= 4; p++) step(p);
    step(6);
    check("skip_code", err_code, 2);
    check("skip_pos", pos, 6);
    check("skip_locked", locked, 0);
    drive(12'h003);
    check("first_wins", err_code, 2);

    // err_clr coincident with a bad-step event: the new error wins
    pulse_clr();
    drive(12'b0000_1010_0000);
    check("pre_code", err_code, 1);
    drive(12'hFFF);
    step(0);
    @(negedge clock);
    led = 12'b0000_0000_0100;
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    repeat (2) @(negedge clock);
    check("clr_race_err", err, 1);
    check("clr_race_code", err_code, 2);
    pulse_clr();
    check("clr_alone_err", err, 0);
    check("clr_alone_code", err_code, 0);

    // Stall: hold pos 3 while locked
    drive(12'hFFF);
    for (int p = 0; p <= 3; p++) step(p);
    check("stall_pre_locked", locked, 1);
    repeat (20) @(negedge clock);
`ifdef CYLON_DECODER_STALL_EN
    check("stall_err", err, 1);
    check("stall_code", err_code, 3);
    check("stall_locked", locked, 0);
`else
    check("nostall_err", err, 0);
    check("nostall_locked", locked, 1);
`endif

    // Asynchronous reset while descending at 6, then resync
    pulse_clr();
    drive(12'hFFF);
    for (int p = 11; p >= 6; p--) step(p);
    check("down6_pos", pos, 6);
    check("down6_dir", dir, 1);
    check("down6_sweeps", sweeps, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pos", pos, 0);
    check("arst_dir", dir, 0);
    check("arst_locked", locked, 0);
    check("arst_sweeps", sweeps, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("resync_acq", locked, 0);
    step(5);
    step(4);
    check("resync_locked", locked, 1);
    check("resync_dir", dir, 1);
    check("resync_pos", pos, 4);
    check("resync_err", err, 0);

    // Disabled: input changes are not evaluated and cause no event on re-enable
    @(negedge clock);
    enable = 1'b0;
    step(3);
    check("dis_pos", pos, 4);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    check("reen_pos", pos, 4);
    check("reen_err", err, 0);
    drive(12'h000);
    step(3);
    check("reen_step_pos", pos, 3);
    check("reen_step_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
